sel_capture_fifo: RTL and testbench

Read-side companion to the `sel`-qualified data path in the procedural testbenches. It captures `din` on every clock where `sel` is high into a small synchronous FIFO, and hands the samples to a consumer over a valid/ready interface. Every sample is either registered or explicitly counted as dropped, so it replaces the incomplete-`if` hold behaviour with defined sequential storage.

---
 rtl/sel_capture_fifo.sv | 80 ++++++++
 tb/tb_sel_capture_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sel_capture_fifo.sv
// Capture FIFO: stores din on every clock where sel is high and hands samples
// to a consumer over valid/ready; rejected captures are counted in drop_cnt.
module sel_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       sel,
    input  logic [WIDTH-1:0]           din,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [7:0]                 drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_count;
    logic [7:0]       r_drop;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && dout_ready;
    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    assign w_push  = sel && (!w_full || w_pop);
    assign w_drop  = sel && w_full && !w_pop;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_drop  <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign dout_valid = !w_empty;
    assign dout       = w_empty ? '0 : r_mem[r_rp];
    assign count      = r_count;
    assign full       = w_full;
    assign empty      = w_empty;
    assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_sel_capture_fifo.sv
// Self-checking bench for sel_capture_fifo: table vectors, hand-written corner
// sequences and randomized traffic compared against a queue-based reference.
module tb_sel_capture_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rstn;
    logic             sel;
    logic [WIDTH-1:0] din;
    logic             dout_valid;
    logic             dout_ready;
    logic [WIDTH-1:0] dout;
    logic [2:0]       count;
    logic             full;
    logic             empty;
    logic [7:0]       drop_cnt;

    int vectors;
    int miscompares;

    logic [WIDTH-1:0] modelQ [$];
    int               modelDrop;

    typedef struct {
        logic       sel;
        logic [7:0] din;
        logic       ready;
        logic       expValid;
        logic [7:0] expDout;
        int         expCount;
        logic       expFull;
        int         expDrop;
    } vec_t;

    vec_t table_v [$];

    sel_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .sel        (sel),
        .din        (din),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAgainstModel();
        int headExp;
        headExp = (modelQ.size() > 0) ? int'(modelQ[0]) : 0;
        checkOutput("model.valid", int'(dout_valid), (modelQ.size() > 0) ? 1 : 0);
        checkOutput("model.dout", int'(dout), headExp);
        checkOutput("model.count", int'(count), modelQ.size());
        checkOutput("model.full", int'(full), (modelQ.size() == DEPTH) ? 1 : 0);
        checkOutput("model.empty", int'(empty), (modelQ.size() == 0) ? 1 : 0);
        checkOutput("model.drop", int'(drop_cnt), modelDrop);
    endtask

    // Drives one cycle of inputs, advances the reference by one edge and compares.
    task automatic applyStimulus(input logic s, input logic [7:0] d, input logic r);
        logic doPop;
        logic isFull;
        sel        = s;
        din        = d;
        dout_ready = r;
        @(posedge clk);
        doPop  = (modelQ.size() > 0) && r;
        isFull = (modelQ.size() == DEPTH);
        if (doPop) void'(modelQ.pop_front());
        if (s && (!isFull || doPop)) modelQ.push_back(d);
        if (s && isFull && !doPop && modelDrop < 255) modelDrop++;
        #1;
        checkAgainstModel();
    endtask

    task automatic addVec(input logic s, input logic [7:0] d, input logic r,
                          input logic v, input logic [7:0] o, input int c,
                          input logic f, input int dr);
        vec_t t;
        t.sel = s; t.din = d; t.ready = r; t.expValid = v;
        t.expDout = o; t.expCount = c; t.expFull = f; t.expDrop = dr;
        table_v.push_back(t);
    endtask

    initial begin
        int lastDrop;
        vectors     = 0;
        miscompares = 0;
        modelDrop   = 0;
        rstn        = 1'b0;
        sel         = 1'b1;
        din         = 8'hAA;
        dout_ready  = 1'b0;

        // Reset values held over two cycles while sel is asserted.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rst.valid", int'(dout_valid), 0);
            checkOutput("rst.dout", int'(dout), 0);
            checkOutput("rst.count", int'(count), 0);
            checkOutput("rst.empty", int'(empty), 1);
            checkOutput("rst.drop", int'(drop_cnt), 0);
        end
        sel  = 1'b0;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Fill, read back, refill, overflow, full push/pop, drain.
        addVec(1, 8'd1, 0, 1, 8'd1, 1, 0, 0);
        addVec(1, 8'd2, 0, 1, 8'd1, 2, 0, 0);
        addVec(1, 8'd3, 0, 1, 8'd1, 3, 0, 0);
        addVec(1, 8'd4, 0, 1, 8'd1, 4, 1, 0);
        addVec(0, 8'd0, 1, 1, 8'd2, 3, 0, 0);
        addVec(0, 8'd0, 1, 1, 8'd3, 2, 0, 0);
        addVec(0, 8'd0, 1, 1, 8'd4, 1, 0, 0);
        addVec(0, 8'd0, 1, 0, 8'd0, 0, 0, 0);
        addVec(1, 8'd1, 0, 1, 8'd1, 1, 0, 0);
        addVec(1, 8'd2, 0, 1, 8'd1, 2, 0, 0);
        addVec(1, 8'd3, 0, 1, 8'd1, 3, 0, 0);
        addVec(1, 8'd4, 0, 1, 8'd1, 4, 1, 0);
        addVec(1, 8'd5, 0, 1, 8'd1, 4, 1, 1);
        addVec(1, 8'd6, 0, 1, 8'd1, 4, 1, 2);
        addVec(1, 8'd7, 0, 1, 8'd1, 4, 1, 3);
        addVec(1, 8'd9, 1, 1, 8'd2, 4, 1, 3);
        addVec(0, 8'd0, 1, 1, 8'd3, 3, 0, 3);
        addVec(0, 8'd0, 1, 1, 8'd4, 2, 0, 3);
        addVec(0, 8'd0, 1, 1, 8'd9, 1, 0, 3);
        addVec(0, 8'd0, 1, 0, 8'd0, 0, 0, 3);

        for (int i = 0; i < table_v.size(); i++) begin
            applyStimulus(table_v[i].sel, table_v[i].din, table_v[i].ready);
            checkOutput($sformatf("vec%0d.valid", i), int'(dout_valid), int'(table_v[i].expValid));
            checkOutput($sformatf("vec%0d.dout", i), int'(dout), int'(table_v[i].expDout));
            checkOutput($sformatf("vec%0d.count", i), int'(count), table_v[i].expCount);
            checkOutput($sformatf("vec%0d.full", i), int'(full), int'(table_v[i].expFull));
            checkOutput($sformatf("vec%0d.drop", i), int'(drop_cnt), table_v[i].expDrop);
        end

        // Drop counter saturation.
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        checkOutput("sat.drop", int'(drop_cnt), 255);
        checkOutput("sat.head", int'(dout), 1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'd0, 1'b1);
        checkOutput("sat.empty", int'(empty), 1);

        // Wrap-around streaming with one-cycle lag.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b1);
            checkOutput("stream.dout", int'(dout), i);
            checkOutput("stream.countLe1", (count <= 3'd1) ? 1 : 0, 1);
            checkOutput("stream.drop", int'(drop_cnt), 255);
        end
        applyStimulus(1'b0, 8'd0, 1'b1);

        // Asynchronous reset between edges.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
        #3 rstn = 1'b0;
        #1;
        modelQ.delete();
        modelDrop = 0;
        checkOutput("arst.valid", int'(dout_valid), 0);
        checkOutput("arst.dout", int'(dout), 0);
        checkOutput("arst.count", int'(count), 0);
        checkOutput("arst.empty", int'(empty), 1);
        checkOutput("arst.drop", int'(drop_cnt), 0);
        #2 rstn = 1'b1;
        applyStimulus(1'b1, 8'h5A, 1'b0);
        checkOutput("arst.dout5A", int'(dout), 8'h5A);
        checkOutput("arst.count1", int'(count), 1);
        applyStimulus(1'b0, 8'd0, 1'b1);
        checkOutput("arst.noStale", int'(empty), 1);

        // Randomized traffic against the reference queue.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 45));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
